// File: rtl/ccg_bist_harness.sv
// BIST harness for generated CCG combinational benchmarks: drives LFSR or exhaustive
// stimulus into a CUT and compacts its (optionally latency-delayed) response into a 32-bit MISR.
module ccg_bist_harness #(
    parameter int          N_IN    = 25,
    parameter int          N_OUT   = 11,
    parameter int          N_PAT   = 1024,
    parameter int          CUT_LAT = 0,
    parameter logic [63:0] SEED    = 64'h1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [31:0]      exp_sig,
    input  logic [N_OUT-1:0] cut_out,
    output logic [N_IN-1:0]  cut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [31:0]      signature,
    output logic [20:0]      pat_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // An all-zero seed would lock the LFSR, so it is silently promoted to 1.
    localparam logic [63:0] SEED_EFF   = (SEED == 64'h0) ? 64'h1 : SEED;
    localparam logic [63:0] LFSR_TAPS  = 64'hD800_0000_0000_0000;
    localparam logic [31:0] MISR_TAPS  = 32'hEDB8_8320;
    localparam logic [20:0] PAT_LAST   = 21'(N_PAT - 1);
    localparam logic [20:0] PAT_MAX    = 21'(N_PAT);
    localparam int          DW         = (CUT_LAT > 0) ? CUT_LAT : 1;
    localparam logic [2:0]  DRAIN_LAST = 3'(DW - 1);

    state_t            state;
    state_t            next_state;
    logic [63:0]       gen;
    logic              mode_q;
    logic [31:0]       sig;
    logic [20:0]       cnt;
    logic [N_IN-1:0]   cut_in_q;
    logic [2:0]        drain_cnt;
    logic              start_ok;
    logic              last_pat;
    logic              vld_now;
    logic              vld_dly;
    logic [63:0]       gen_step;
    logic [63:0]       out_ext;
    logic [31:0]       sig_step;

    always_comb begin
        start_ok = start && ((state == IDLE) || (state == DONE));
        last_pat = (state == RUN) && (cnt == PAT_LAST);
        vld_now  = (state == RUN);
        out_ext  = 64'(cut_out);
        sig_step = {1'b0, sig[31:1]} ^ (sig[0] ? MISR_TAPS : 32'h0)
                 ^ out_ext[31:0] ^ out_ext[63:32];
        if (mode_q) begin
            gen_step = gen + 64'd1;
        end else begin
            gen_step = {1'b0, gen[63:1]} ^ (gen[0] ? LFSR_TAPS : 64'h0);
        end
    end

    // The valid pipeline lines each compaction up with the response of a registered CUT.
    generate
        if (CUT_LAT == 0) begin : g_nolat
            assign vld_dly = vld_now;
        end else begin : g_lat
            logic [CUT_LAT-1:0] vld_sr;

            always_ff @(posedge clk) begin
                if (!rst_n || abort) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr[0] <= vld_now;
                    for (int i = 1; i < CUT_LAT; i++) begin
                        vld_sr[i] <= vld_sr[i-1];
                    end
                end
            end

            assign vld_dly = vld_sr[CUT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_pat) begin
                    next_state = (CUT_LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state = IDLE;
        end
    end

    // Abort freezes signature and count for inspection but parks the CUT on an all-zero vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gen       <= 64'h0;
            mode_q    <= 1'b0;
            sig       <= 32'h0;
            cnt       <= 21'h0;
            cut_in_q  <= '0;
            drain_cnt <= 3'h0;
        end else if (abort) begin
            cut_in_q  <= '0;
            drain_cnt <= 3'h0;
        end else begin
            if (start_ok) begin
                mode_q <= mode;
                cnt    <= 21'h0;
                if (mode) begin
                    gen      <= 64'h0;
                    cut_in_q <= '0;
                end else begin
                    gen      <= SEED_EFF;
                    cut_in_q <= SEED_EFF[N_IN-1:0];
                end
            end else if (state == RUN) begin
                gen <= gen_step;
                if (cnt != PAT_MAX) begin
                    cnt <= cnt + 21'd1;
                end
                if (!last_pat) begin
                    cut_in_q <= gen_step[N_IN-1:0];
                end
            end

            if (start_ok) begin
                sig <= 32'hFFFF_FFFF;
            end else if (vld_dly) begin
                sig <= sig_step;
            end

            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 3'd1;
            end else begin
                drain_cnt <= 3'h0;
            end
        end
    end

    assign cut_in    = cut_in_q;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign pass      = (state == DONE) && (sig == exp_sig);
    assign signature = sig;
    assign pat_cnt   = cnt;

endmodule
